// File: rtl/vip_axi4_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vip_axi4_rd_arbiter
// Description : Round-robin arbiter sharing one AXI4 read port among
//               NR_OF_REQ_P requesters, one burst outstanding at a time.
//               Define VIP_AXI4_RD_ARBITER_TIMEOUT_EN to enable the
//               data-phase stall watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module vip_axi4_rd_arbiter #(
    parameter int NR_OF_REQ_P = 4,
    parameter int AR_WIDTH_P  = 53,
    parameter int TIMEOUT_P   = 1024
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NR_OF_REQ_P*AR_WIDTH_P-1:0] req_ar,
    input  logic [NR_OF_REQ_P-1:0]            req_arvalid,
    output logic [NR_OF_REQ_P-1:0]            req_arready,
    output logic [NR_OF_REQ_P-1:0]            req_rvalid,
    input  logic [NR_OF_REQ_P-1:0]            req_rready,
    output logic [AR_WIDTH_P-1:0]             m_ar,
    output logic                              m_arvalid,
    input  logic                              m_arready,
    input  logic                              m_rvalid,
    input  logic                              m_rlast,
    output logic                              m_rready,
    output logic [NR_OF_REQ_P-1:0]            grant,
    output logic                              timeout_err
);

    localparam int IDX_W = (NR_OF_REQ_P > 1) ? $clog2(NR_OF_REQ_P) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [IDX_W-1:0]         r_owner;
    logic [IDX_W-1:0]         r_last_owner;
    logic [IDX_W-1:0]         w_win_idx;
    logic [NR_OF_REQ_P-1:0]   r_grant;
    logic                     w_any_req;
    logic                     w_in_addr;
    logic                     w_in_data;
    logic                     w_ar_hs;
    logic                     w_r_hs;
    logic                     w_r_last_hs;
    logic                     w_timeout;

    assign w_any_req   = |req_arvalid;
    assign w_in_addr   = (r_state == ST_ADDR);
    assign w_in_data   = (r_state == ST_DATA);
    assign w_ar_hs     = w_in_addr & req_arvalid[r_owner] & m_arready;
    assign w_r_hs      = w_in_data & m_rvalid & req_rready[r_owner];
    assign w_r_last_hs = w_r_hs & m_rlast;

    // Scan from farthest to nearest so the nearest set bit after last_owner wins.
    always_comb begin : p_round_robin
        logic [IDX_W-1:0] v_cand;
        v_cand    = '0;
        w_win_idx = r_last_owner;
        for (int k = NR_OF_REQ_P; k >= 1; k--) begin
            v_cand = IDX_W'((int'(r_last_owner) + k) % NR_OF_REQ_P);
            if (req_arvalid[v_cand]) begin
                w_win_idx = v_cand;
            end
        end
    end

    always_comb begin : p_next_state
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_any_req)                 w_state_nxt = ST_ADDR;
            ST_ADDR: if (w_ar_hs)                   w_state_nxt = ST_DATA;
            ST_DATA: if (w_r_last_hs || w_timeout)  w_state_nxt = ST_IDLE;
            default:                                w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_owner      <= '0;
            r_last_owner <= IDX_W'(NR_OF_REQ_P - 1);
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && w_any_req) begin
                r_owner <= w_win_idx;
                r_grant <= {{(NR_OF_REQ_P-1){1'b0}}, 1'b1} << w_win_idx;
            end else if (w_r_last_hs || w_timeout) begin
                r_grant <= '0;
                if (w_r_last_hs) begin
                    r_last_owner <= r_owner;
                end
            end
        end
    end

    assign m_ar        = w_in_addr ? req_ar[int'(r_owner)*AR_WIDTH_P +: AR_WIDTH_P] : '0;
    assign m_arvalid   = w_in_addr & req_arvalid[r_owner];
    assign req_arready = (w_in_addr & m_arready) ? r_grant : '0;
    assign req_rvalid  = (w_in_data & m_rvalid) ? r_grant : '0;
    assign m_rready    = w_in_data & req_rready[r_owner];
    assign grant       = r_grant;

`ifdef VIP_AXI4_RD_ARBITER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_P + 1);

    logic [CNT_W-1:0] r_stall_cnt;
    logic             r_timeout_err;

    // Counter idles at zero outside DATA, so entry to DATA starts it cleared.
    assign w_timeout = w_in_data && !w_r_hs && (r_stall_cnt == CNT_W'(TIMEOUT_P - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt   <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_timeout;
            if (!w_in_data || w_r_hs || w_timeout) begin
                r_stall_cnt <= '0;
            end else begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_P > 0);
    assign w_timeout        = 1'b0;
    assign timeout_err      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/vip_axi4_rd_arbiter.md
VIP_AXI4_RD_ARBITER -- requirements
Module: vip_axi4_rd_arbiter

Interface
REQ-001 SHALL have parameter NR_OF_REQ_P, default 4: number of requesters (2..16).
REQ-002 SHALL have parameter AR_WIDTH_P, default 53: width of the packed AR payload {arid, araddr, arlen, arsize, arburst}.
REQ-003 SHALL have parameter TIMEOUT_P, default 1024: data-phase stall limit in cycles (used only under REQ-029).
REQ-004 SHALL have port clk, in, 1: single clock; all logic on rising edge.
REQ-005 SHALL have port rst, in, 1: asynchronous, active-high reset.
REQ-006 SHALL have port req_ar, in, NR_OF_REQ_P*AR_WIDTH_P: requester AR payloads; requester i occupies slice i.
REQ-007 SHALL have port req_arvalid, in, NR_OF_REQ_P: per-requester AR valid.
REQ-008 SHALL have port req_arready, out, NR_OF_REQ_P: per-requester AR ready.
REQ-009 SHALL have port req_rvalid, out, NR_OF_REQ_P: per-requester R valid; R payload is the shared m-side rid/rdata/rresp/rlast, broadcast outside this block.
REQ-010 SHALL have port req_rready, in, NR_OF_REQ_P: per-requester R ready.
REQ-011 SHALL have port m_ar, out, AR_WIDTH_P: AR payload to the shared AXI4 read port.
REQ-012 SHALL have ports m_arvalid (out, 1) and m_arready (in, 1): shared AR handshake.
REQ-013 SHALL have ports m_rvalid (in, 1), m_rlast (in, 1) and m_rready (out, 1): shared R handshake and last beat.
REQ-014 SHALL have port grant, out, NR_OF_REQ_P: one-hot current owner; all-zero in IDLE.
REQ-015 SHALL have port timeout_err, out, 1: one-cycle pulse on data-phase timeout.

Function
REQ-016 SHALL implement FSM states IDLE, ADDR and DATA, with one burst outstanding at a time.
REQ-017 IDLE: when any req_arvalid bit is 1, SHALL register a round-robin winner into grant and move to ADDR on the next edge (1-cycle arbitration latency).
REQ-018 Round-robin search SHALL start at index (last_owner+1) mod NR_OF_REQ_P and take the first set bit.
REQ-019 ADDR: m_ar SHALL equal the granted requester's slice, m_arvalid SHALL equal req_arvalid[g], req_arready[g] SHALL equal m_arready, and all other req_arready bits SHALL be 0.
REQ-020 ADDR: on m_arvalid & m_arready, SHALL move to DATA; if req_arvalid[g] deasserts without a handshake, SHALL remain in ADDR holding grant.
REQ-021 DATA: req_rvalid[g] SHALL equal m_rvalid, m_rready SHALL equal req_rready[g], and all other req_rvalid bits SHALL be 0.
REQ-022 DATA: on m_rvalid & m_rready & m_rlast, SHALL store g as last_owner, clear grant and return to IDLE; re-arbitration SHALL occur in that IDLE cycle.
REQ-023 m_arvalid, m_rready, req_arready and req_rvalid SHALL all be 0 in IDLE.
REQ-024 Requests that change in IDLE SHALL be sampled only at the arbitration edge; later changes SHALL NOT alter grant until return to IDLE.

Reset
REQ-025 While rst is 1, SHALL force the state to IDLE, grant to 0, last_owner to NR_OF_REQ_P-1 (so requester 0 has first priority), and timeout_err and the timeout counter to 0.
REQ-026 Reset asserted mid-burst SHALL abandon the burst immediately, with all outputs 0 asynchronously.
REQ-027 After rst deasserts, the first arbitration SHALL occur on the first edge on which any req_arvalid is 1.

Configuration
REQ-028 Macro VIP_AXI4_RD_ARBITER_TIMEOUT_EN SHALL select the data-phase watchdog.
REQ-029 With the macro defined: a counter SHALL clear on entry to DATA and on each R handshake, and SHALL increment on every other DATA cycle; on reaching TIMEOUT_P it SHALL pulse timeout_err for 1 cycle, clear grant and return to IDLE.
REQ-030 With the macro undefined: no counter SHALL exist, timeout_err SHALL be tied to 0, and DATA SHALL wait indefinitely for rlast.

Verification
REQ-031 Reset, then req_arvalid=4'b0001 with arlen=3 and m_arready=1 -> grant=0001 one cycle later, AR handshake, 4 beats forwarded only to req 0, IDLE after the rlast beat.
REQ-032 req_arvalid=4'b1111 held, single-beat bursts -> grant sequence 0001, 0010, 0100, 1000, 0001.
REQ-033 Burst owned by req 2, req_rready[2]=0 for 5 cycles with m_rvalid=1 -> m_rready=0, no beat consumed, other req_rvalid bits 0 throughout.
REQ-034 rst pulsed for 1 cycle during the DATA phase of an 8-beat burst -> all outputs 0 at once, next grant goes to req 0.
REQ-035 Macro defined, TIMEOUT_P=16, m_rvalid held 0 in DATA -> timeout_err high for exactly 1 cycle at the 16th stall cycle, then IDLE; macro undefined -> state stays DATA and timeout_err stays 0.
